// File: rtl/imm_ls_ext_stage.sv
// Registered immediate / load / store extension stage with valid-ready handshake.
// Define IMMEXT_SKID_EN for a two-entry skid buffer with a registered in_ready.
module imm_ls_ext_stage #(
  parameter int XLEN = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_op,
  input  logic [31:0]                   in_instr,
  input  logic [XLEN-1:0]               in_data,
  input  logic [$clog2(XLEN/8)-1:0]     in_off,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_data,
  output logic [XLEN/8-1:0]             out_be,
  output logic [1:0]                    out_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [3:0] OP_I   = 4'd0;
  localparam logic [3:0] OP_S   = 4'd1;
  localparam logic [3:0] OP_B   = 4'd2;
  localparam logic [3:0] OP_J   = 4'd3;
  localparam logic [3:0] OP_U   = 4'd4;
  localparam logic [3:0] OP_LB  = 4'd5;
  localparam logic [3:0] OP_LH  = 4'd6;
  localparam logic [3:0] OP_LW  = 4'd7;
  localparam logic [3:0] OP_LBU = 4'd8;
  localparam logic [3:0] OP_LHU = 4'd9;
  localparam logic [3:0] OP_LWU = 4'd10;
  localparam logic [3:0] OP_LD  = 4'd11;
  localparam logic [3:0] OP_SB  = 4'd12;
  localparam logic [3:0] OP_SH  = 4'd13;
  localparam logic [3:0] OP_SW  = 4'd14;
  localparam logic [3:0] OP_SD  = 4'd15;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_ILL = 2'b10;

  typedef logic        [XLEN-1:0] xlen_t;
  typedef logic signed [XLEN-1:0] sxlen_t;
  typedef logic        [NB-1:0]   be_t;

  typedef struct packed {
    xlen_t      data;
    be_t        be;
    logic [1:0] err;
  } res_t;

  function automatic sxlen_t sext8(input logic signed [7:0] v);
    return sxlen_t'(v);
  endfunction

  function automatic sxlen_t sext16(input logic signed [15:0] v);
    return sxlen_t'(v);
  endfunction

  function automatic sxlen_t sext32(input logic signed [31:0] v);
    return sxlen_t'(v);
  endfunction

  function automatic res_t compute(
    input logic [3:0]      op,
    input logic [31:0]     ins,
    input xlen_t           d,
    input logic [OFFW-1:0] off
  );
    res_t  r;
    xlen_t sh;
    logic  mis;
    logic  ill;
    r   = '0;
    mis = 1'b0;
    sh  = d >> {off, 3'b000};
    // Ops that need a 64-bit datapath are rejected ahead of any alignment fault.
    ill = (XLEN == 32) && ((op == OP_LWU) || (op == OP_LD) || (op == OP_SD));
    case (op)
      OP_I:   r.data = xlen_t'(sext32({{20{ins[31]}}, ins[31:20]}));
      OP_S:   r.data = xlen_t'(sext32({{20{ins[31]}}, ins[31:25], ins[11:7]}));
      OP_B:   r.data = xlen_t'(sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                                       ins[11:8], 1'b0}));
      OP_J:   r.data = xlen_t'(sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                                       ins[30:21], 1'b0}));
      OP_U:   r.data = xlen_t'(sext32({ins[31:12], 12'h000}));
      OP_LB:  r.data = xlen_t'(sext8(sh[7:0]));
      OP_LH: begin
        r.data = xlen_t'(sext16(sh[15:0]));
        mis    = off[0];
      end
      OP_LW: begin
        r.data = xlen_t'(sext32(sh[31:0]));
        mis    = (off[1:0] != 2'b00);
      end
      OP_LBU: r.data = xlen_t'(sh[7:0]);
      OP_LHU: begin
        r.data = xlen_t'(sh[15:0]);
        mis    = off[0];
      end
      OP_LWU: begin
        r.data = xlen_t'(sh[31:0]);
        mis    = (off[1:0] != 2'b00);
      end
      OP_LD: begin
        r.data = sh;
        mis    = (off != '0);
      end
      OP_SB: begin
        r.data = {NB{d[7:0]}};
        r.be   = be_t'(1) << off;
      end
      OP_SH: begin
        r.data = {(NB/2){d[15:0]}};
        r.be   = be_t'(2'b11) << off;
        mis    = off[0];
      end
      OP_SW: begin
        r.data = {(NB/4){d[31:0]}};
        r.be   = be_t'(4'hF) << off;
        mis    = (off[1:0] != 2'b00);
      end
      default: begin
        r.data = d;
        r.be   = '1;
        mis    = (off != '0);
      end
    endcase
    if (ill) begin
      r     = '0;
      r.err = ERR_ILL;
    end else if (mis) begin
      r     = '0;
      r.err = ERR_MIS;
    end else begin
      r.err = ERR_OK;
    end
    return r;
  endfunction

  // The opcode field does not take part in immediate formation.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  // Stage p0: combinational extension of the incoming request.
  res_t res_p0;
  assign res_p0 = compute(in_op, in_instr, in_data, in_off);

  // Stage p1: output register (and skid entry in the buffered build).
  res_t res_p1;
  logic vld_p1;

`ifdef IMMEXT_SKID_EN
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t state_p1;
  res_t   skid_p1;
  logic   rdy_p1;
  logic   acc;
  logic   drn;

  assign acc = in_valid && rdy_p1;
  assign drn = vld_p1 && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= S_EMPTY;
      vld_p1   <= 1'b0;
      rdy_p1   <= 1'b1;
      res_p1   <= '0;
    end else begin
      case (state_p1)
        S_EMPTY: begin
          if (acc) begin
            res_p1   <= res_p0;
            vld_p1   <= 1'b1;
            state_p1 <= S_ONE;
          end
        end
        S_ONE: begin
          if (acc && !drn) begin
            state_p1 <= S_TWO;
            rdy_p1   <= 1'b0;
          end else if (drn && !acc) begin
            vld_p1   <= 1'b0;
            state_p1 <= S_EMPTY;
          end else if (acc && drn) begin
            res_p1   <= res_p0;
          end
        end
        S_TWO: begin
          if (drn) begin
            res_p1   <= skid_p1;
            rdy_p1   <= 1'b1;
            state_p1 <= S_ONE;
          end
        end
        default: begin
          state_p1 <= S_EMPTY;
          vld_p1   <= 1'b0;
          rdy_p1   <= 1'b1;
        end
      endcase
    end
  end

  // Second entry captures the request that arrives while the head is stalled.
  always_ff @(posedge clk) begin
    if ((state_p1 == S_ONE) && acc && !drn) begin
      skid_p1 <= res_p0;
    end
  end

  assign in_ready = rdy_p1;
`else
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t state_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= S_EMPTY;
      res_p1   <= '0;
    end else if (in_ready) begin
      if (in_valid) begin
        state_p1 <= S_FULL;
        res_p1   <= res_p0;
      end else begin
        state_p1 <= S_EMPTY;
      end
    end
  end

  assign vld_p1   = (state_p1 == S_FULL);
  assign in_ready = !vld_p1 || out_ready;
`endif

  assign out_valid = vld_p1;
  assign out_data  = res_p1.data;
  assign out_be    = res_p1.be;
  assign out_err   = res_p1.err;

endmodule

// File: tb/tb_imm_ls_ext_stage.sv
// Directed, table-driven bench for imm_ls_ext_stage at XLEN=32 and XLEN=64.
module tb_imm_ls_ext_stage;

  typedef struct {
    logic        w64;
    logic [3:0]  op;
    logic [31:0] instr;
    logic [63:0] data;
    logic [2:0]  off;
    logic [63:0] exp_data;
    logic [7:0]  exp_be;
    logic [1:0]  exp_err;
  } vec_t;

`ifdef IMMEXT_SKID_EN
  localparam int STALL_ACC = 2;
`else
  localparam int STALL_ACC = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [3:0]  op32;
  logic [31:0] instr32, data32, odata32;
  logic [1:0]  off32, err32;
  logic [3:0]  be32;

  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [3:0]  op64;
  logic [31:0] instr64;
  logic [63:0] data64, odata64;
  logic [2:0]  off64;
  logic [1:0]  err64;
  logic [7:0]  be64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_ls_ext_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_op(op32), .in_instr(instr32), .in_data(data32), .in_off(off32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(odata32),
    .out_be(be32), .out_err(err32)
  );

  imm_ls_ext_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_op(op64), .in_instr(instr64), .in_data(data64), .in_off(off64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(odata64),
    .out_be(be64), .out_err(err64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [3:0] op, input logic [31:0] ins,
                              input logic [63:0] d, input logic [2:0] off,
                              input logic [63:0] ed, input logic [7:0] eb, input logic [1:0] ee);
    vec_t v;
    v.w64 = w; v.op = op; v.instr = ins; v.data = d; v.off = off;
    v.exp_data = ed; v.exp_be = eb; v.exp_err = ee;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    if (v.w64) begin
      in_valid64 = 1'b1; op64 = v.op; instr64 = v.instr; data64 = v.data; off64 = v.off;
    end else begin
      in_valid32 = 1'b1; op32 = v.op; instr32 = v.instr; data32 = v.data[31:0];
      off32 = v.off[1:0];
    end
    @(negedge clk);
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    if (v.w64) begin
      check($sformatf("vec%0d_valid", idx), {63'd0, out_valid64}, 64'd1);
      check($sformatf("vec%0d_data", idx), odata64, v.exp_data);
      check($sformatf("vec%0d_be", idx), {56'd0, be64}, {56'd0, v.exp_be});
      check($sformatf("vec%0d_err", idx), {62'd0, err64}, {62'd0, v.exp_err});
    end else begin
      check($sformatf("vec%0d_valid", idx), {63'd0, out_valid32}, 64'd1);
      check($sformatf("vec%0d_data", idx), {32'd0, odata32}, v.exp_data);
      check($sformatf("vec%0d_be", idx), {60'd0, be32}, {56'd0, v.exp_be});
      check($sformatf("vec%0d_err", idx), {62'd0, err32}, {62'd0, v.exp_err});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[$];
    int sent, recv, cyc, stale;

    // 32-bit: immediates
    vecs.push_back(mk(0, 4'd0, 32'hFFF00093, 0, 0, 64'hFFFFFFFF, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd0, 32'h00500093, 0, 3, 64'h00000005, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd1, 32'hFE112E23, 0, 0, 64'hFFFFFFFC, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd2, 32'h00208463, 0, 0, 64'h00000008, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd2, 32'hFE000EE3, 0, 0, 64'hFFFFFFFC, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd3, 32'h0080006F, 0, 0, 64'h00000008, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd4, 32'h12345037, 0, 0, 64'h12345000, 8'h0, 2'b00));
    // 32-bit: loads
    vecs.push_back(mk(0, 4'd5, 0, 64'h12AB80FF, 1, 64'hFFFFFF80, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd8, 0, 64'h12AB80FF, 1, 64'h00000080, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd9, 0, 64'h12AB80FF, 2, 64'h000012AB, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd6, 0, 64'h12AB80FF, 0, 64'hFFFF80FF, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd6, 0, 64'h12AB80FF, 1, 64'h0, 8'h0, 2'b01));
    vecs.push_back(mk(0, 4'd7, 0, 64'h12AB80FF, 0, 64'h12AB80FF, 8'h0, 2'b00));
    vecs.push_back(mk(0, 4'd7, 0, 64'h12AB80FF, 2, 64'h0, 8'h0, 2'b01));
    vecs.push_back(mk(0, 4'd10, 0, 64'h12AB80FF, 0, 64'h0, 8'h0, 2'b10));
    vecs.push_back(mk(0, 4'd10, 0, 64'h12AB80FF, 1, 64'h0, 8'h0, 2'b10));
    vecs.push_back(mk(0, 4'd11, 0, 64'h12AB80FF, 0, 64'h0, 8'h0, 2'b10));
    // 32-bit: stores
    vecs.push_back(mk(0, 4'd12, 0, 64'h000000A5, 3, 64'hA5A5A5A5, 8'h8, 2'b00));
    vecs.push_back(mk(0, 4'd13, 0, 64'h0000BEEF, 2, 64'hBEEFBEEF, 8'hC, 2'b00));
    vecs.push_back(mk(0, 4'd13, 0, 64'h0000BEEF, 1, 64'h0, 8'h0, 2'b01));
    vecs.push_back(mk(0, 4'd14, 0, 64'hDEADBEEF, 0, 64'hDEADBEEF, 8'hF, 2'b00));
    vecs.push_back(mk(0, 4'd14, 0, 64'hDEADBEEF, 2, 64'h0, 8'h0, 2'b01));
    vecs.push_back(mk(0, 4'd15, 0, 64'hDEADBEEF, 0, 64'h0, 8'h0, 2'b10));
    // 64-bit
    vecs.push_back(mk(1, 4'd4, 32'h800002B7, 0, 0, 64'hFFFFFFFF80000000, 8'h0, 2'b00));
    vecs.push_back(mk(1, 4'd3, 32'h0080006F, 0, 0, 64'h8, 8'h0, 2'b00));
    vecs.push_back(mk(1, 4'd0, 32'hFFF00093, 0, 0, 64'hFFFFFFFFFFFFFFFF, 8'h0, 2'b00));
    vecs.push_back(mk(1, 4'd7, 0, 64'h8000000012345678, 4, 64'hFFFFFFFF80000000, 8'h0, 2'b00));
    vecs.push_back(mk(1, 4'd10, 0, 64'h8000000012345678, 4, 64'h0000000080000000, 8'h0, 2'b00));
    vecs.push_back(mk(1, 4'd5, 0, 64'h8000000012345678, 7, 64'hFFFFFFFFFFFFFF80, 8'h0, 2'b00));
    vecs.push_back(mk(1, 4'd11, 0, 64'h8000000012345678, 0, 64'h8000000012345678, 8'h0, 2'b00));
    vecs.push_back(mk(1, 4'd11, 0, 64'h8000000012345678, 4, 64'h0, 8'h0, 2'b01));
    vecs.push_back(mk(1, 4'd15, 0, 64'h0123456789ABCDEF, 0, 64'h0123456789ABCDEF, 8'hFF, 2'b00));
    vecs.push_back(mk(1, 4'd14, 0, 64'h00000000DEADBEEF, 4, 64'hDEADBEEFDEADBEEF, 8'hF0, 2'b00));
    vecs.push_back(mk(1, 4'd14, 0, 64'h00000000DEADBEEF, 2, 64'h0, 8'h0, 2'b01));
    vecs.push_back(mk(1, 4'd13, 0, 64'h0000000000001234, 6, 64'h1234123412341234, 8'hC0, 2'b00));
    vecs.push_back(mk(1, 4'd12, 0, 64'h000000000000005A, 7, 64'h5A5A5A5A5A5A5A5A, 8'h80, 2'b00));

    rst = 1'b1;
    in_valid32 = 1'b0; out_ready32 = 1'b1; op32 = 0; instr32 = 0; data32 = 0; off32 = 0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; op64 = 0; instr64 = 0; data64 = 0; off64 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid32}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready32}, 64'd1);
    check("rst_out_data", {32'd0, odata32}, 64'd0);
    check("rst_out_be", {60'd0, be32}, 64'd0);
    check("rst_out_err", {62'd0, err32}, 64'd0);
    check("rst_out_valid64", {63'd0, out_valid64}, 64'd0);
    check("rst_in_ready64", {63'd0, in_ready64}, 64'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Back-to-back stream against a 3-cycle output stall.
    sent = 0; recv = 0; cyc = 0;
    op32 = 4'd7; off32 = 2'd0; instr32 = 32'd0;
    while (recv < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready32 = (cyc >= 3);
      in_valid32  = (sent < 8);
      data32      = 32'h1000 + sent;
      #1;
      if (cyc == 2) begin
        check("stall_in_ready", {63'd0, in_ready32}, 64'd0);
        check("stall_accepts", 64'(sent), 64'(STALL_ACC));
        check("stall_out_valid", {63'd0, out_valid32}, 64'd1);
        check("stall_hold_data", {32'd0, odata32}, 64'h1000);
      end
      if (in_valid32 && in_ready32) sent++;
      if (out_valid32 && out_ready32) begin
        check($sformatf("stream_order%0d", recv), {32'd0, odata32}, 64'h1000 + 64'(recv));
        recv++;
      end
      cyc++;
    end
    in_valid32 = 1'b0;
    check("stream_received", 64'(recv), 64'd8);
    check("stream_sent", 64'(sent), 64'd8);
    @(negedge clk);
    check("stream_no_dup", {63'd0, out_valid32}, 64'd0);

    // Reset with entries held must flush them.
    out_ready32 = 1'b0;
    op32 = 4'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid32 = 1'b1;
      data32 = 32'hBAD0 + k;
    end
    @(negedge clk);
    in_valid32 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {63'd0, out_valid32}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready32}, 64'd1);
    check("midrst_out_data", {32'd0, odata32}, 64'd0);
    check("midrst_out_be", {60'd0, be32}, 64'd0);
    check("midrst_out_err", {62'd0, err32}, 64'd0);
    rst = 1'b0;
    out_ready32 = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid32) stale++;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_ls_ext_stage.md
# imm_ls_ext_stage

Registered, handshaked successor of the combinational immediate extender. One unit covers immediate generation (I/S/B/J/U), load-data alignment and extension, and store-data lane replication with byte enables, for XLEN 32 or 64. It sits between decode/memory-response and execute/writeback as one pipeline stage with valid/ready flow control.

## Interface
- XLEN, 32: datapath width; legal values 32, 64.
- NB, XLEN/8 (localparam): byte lanes; OFFW = log2(NB).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage accepts request this cycle.
- in_op  in  4  0 I, 1 S, 2 B, 3 J, 4 U, 5 LB, 6 LH, 7 LW, 8 LBU, 9 LHU, 10 LWU, 11 LD, 12 SB, 13 SH, 14 SW, 15 SD.
- in_instr  in  32  instruction word (ops 0-4).
- in_data  in  XLEN  raw aligned memory word (loads) or rs2 value (stores).
- in_off  in  OFFW  byte address offset (ops 5-15).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  XLEN  extended immediate / load result / lane-replicated store data.
- out_be  out  NB  byte enables (stores only; else 0).
- out_err  out  2  00 ok, 01 misaligned, 10 op illegal for XLEN.

## Operation
- Immediates (bit layout fixed by ISA): I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; U {instr[31:12],12'b0}. All sign-extended from instr[31] to XLEN, including U when XLEN=64.
- Loads: field = in_data >> (8*in_off); LB/LH/LW sign-extend 8/16/32 bits; LBU/LHU/LWU zero-extend; LD passes 64 bits.
- Stores: SB replicates byte NB times, be = 1<<off; SH replicates halfword, be = 2'b11<<off; SW replicates word, be = 4'hF<<off; SD data as-is, be = all ones.
- Alignment: H needs off[0]=0; W needs off[1:0]=0; D needs off=0. Violation -> err=01, data=0, be=0.
- XLEN=32: LWU, LD, SD -> err=10, data=0, be=0. Illegal check has priority over misalignment.
- in_off ignored for ops 0-4.
- Transfer occurs on valid&&ready at each side; accepted results leave in acceptance order, none dropped or duplicated.

## Timing
- Latency: 1 cycle from input acceptance to out_valid (empty stage).
- Throughput: 1 result/cycle while out_ready=1.
- Reset values: out_valid=0, out_data=0, out_be=0, out_err=0, in_ready=1 (skid build and plain build).
- out_data/out_be/out_err hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all held entries discarded; next cycle identical to post-reset.
- Simultaneous accept and drain on a full one-entry stage is allowed (plain build) and leaves occupancy unchanged.

## Configuration
- IMMEXT_SKID_EN defined: two-entry skid buffer; states EMPTY -> (accept) ONE; ONE -> (accept, no drain) TWO, (drain, no accept) EMPTY, else ONE; TWO -> (drain) ONE. in_ready = registered, 1 in EMPTY/ONE, 0 in TWO; no combinational out_ready->in_ready path.
- Undefined: single output register; in_ready = !out_valid || out_ready (combinational); two states EMPTY/FULL.
- Functional results and ordering identical in both builds.

## Test plan
- Reset, then I-op instr=0xFFF00093 (XLEN=32) -> one cycle later out_valid=1, out_data=0xFFFFFFFF, err=00.
- XLEN=64, U-op instr=0x800002B7 -> out_data=0xFFFFFFFF80000000; J-op instr=0x0080006F -> out_data=8.
- LB in_data=0x12AB80FF off=1 -> 0xFFFFFF80; LHU off=2 -> 0x000012AB; LH off=1 -> err=01, data=0.
- SB in_data=0x000000A5 off=3 -> data=0xA5A5A5A5, be=4'b1000; XLEN=32 SD -> err=10, be=0.
- Back-to-back 8 requests with out_ready held 0 for 3 cycles then 1 -> skid build: in_ready drops after 2 accepted, all 8 out in order, no loss; plain build: in_ready=0 while full and stalled.
- Assert rst with two entries held -> next cycle out_valid=0, in_ready=1, stale results never appear.
